// File: rtl/fft_io_sequencer_radix2.sv
// Host-side sequencer for the 16-point radix-2 FFT core: load a frame, start, wait for done, unload.
// Optional FFT_SEQ_BITREV_EN: unload in bit-reversed register order (natural frequency order).
module fft_io_sequencer_radix2 #(
  parameter int N       = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_re,
  input  logic [DW-1:0]        in_im,
  output logic                 load_we,
  output logic [$clog2(N)-1:0] load_addr,
  output logic [DW-1:0]        load_re,
  output logic [DW-1:0]        load_im,
  output logic                 core_start,
  input  logic                 core_done,
  output logic [$clog2(N)-1:0] rd_addr,
  input  logic [DW-1:0]        rd_re,
  input  logic [DW-1:0]        rd_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_re,
  output logic [DW-1:0]        out_im,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err_timeout
);
  localparam int AW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);

  // Both streams use strict valid/ready: a transfer happens on a rising edge
  // where valid && ready; valid never depends on ready of the same interface.
  typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [WW-1:0] wdog;
  logic          err_q;
  logic          in_hs;
  logic          out_hs;
  logic          idx_last;

  function automatic logic [AW-1:0] map_idx(input logic [AW-1:0] i);
    logic [AW-1:0] r;
`ifdef FFT_SEQ_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = i[AW-1-b];
`else
    r = i;
`endif
    return r;
  endfunction

  assign in_ready    = (state == LOAD);
  assign in_hs       = in_valid && in_ready;
  assign out_valid   = (state == UNLOAD);
  assign out_hs      = out_valid && out_ready;
  assign idx_last    = (idx == AW'(N - 1));

  // Data-side outputs are gated to zero whenever their strobe is low.
  assign load_we     = in_hs;
  assign load_addr   = load_we ? idx : '0;
  assign load_re     = load_we ? in_re : '0;
  assign load_im     = load_we ? in_im : '0;
  assign core_start  = (state == START);
  assign rd_addr     = out_valid ? map_idx(idx) : '0;
  assign out_re      = out_valid ? rd_re : '0;
  assign out_im      = out_valid ? rd_im : '0;
  assign out_last    = out_valid && idx_last;
  assign busy        = !((state == LOAD) && (idx == '0));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      idx   <= '0;
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        LOAD: begin
          if (in_hs) begin
            idx <= idx + 1'b1;
            if (idx_last) state <= START;
          end
        end
        START: begin
          state <= WAIT;
          wdog  <= '0;
        end
        WAIT: begin
          // done has priority over watchdog expiry in the same cycle
          if (core_done) begin
            state <= UNLOAD;
            idx   <= '0;
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            state <= LOAD;
            idx   <= '0;
            err_q <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        UNLOAD: begin
          if (out_hs) begin
            idx <= idx + 1'b1;
            if (idx_last) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_io_sequencer_radix2.sv
// Self-checking bench: randomized streams, a behavioural core model and a frame-level reference model.
module tb_fft_io_sequencer_radix2;
  localparam int N       = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          load_we;
  logic [3:0]    load_addr;
  logic [DW-1:0] load_re;
  logic [DW-1:0] load_im;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [3:0]    rd_addr;
  logic [DW-1:0] rd_re;
  logic [DW-1:0] rd_im;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_last;
  logic          busy;
  logic          err_timeout;

  fft_io_sequencer_radix2 #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .load_we(load_we), .load_addr(load_addr), .load_re(load_re), .load_im(load_im),
    .core_start(core_start), .core_done(core_done),
    .rd_addr(rd_addr), .rd_re(rd_re), .rd_im(rd_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- core model (register file + done delay) ----------------
  logic [DW-1:0] mem_re [N];
  logic [DW-1:0] mem_im [N];
  logic [DW-1:0] res_re [N];
  logic [DW-1:0] res_im [N];
  assign rd_re = res_re[rd_addr];
  assign rd_im = res_im[rd_addr];

  // ---------------- knobs ----------------
  int mode_in;      // 0 random valid/data, 1 ramp re=k im=-k with valid always high
  int p_valid;
  int or_mode;      // 0 always ready, 1 random, 2 toggle
  int core_delay;   // 0 = core never answers
  bit spurious;
  bit rst_req;

  // ---------------- reference model ----------------
  int m_ph;         // 0 collecting, 1 start cycle, 2 waiting on core, 3 draining
  int m_acc, m_wc, m_k, m_frames;
  bit m_err;
  int done_cnt;

  // ---------------- stats ----------------
  int cyc;
  int st_acc16, st_start_cyc, st_start_cnt, st_done_cyc, st_first_ov;
  int st_err_cnt, st_err_cyc, st_xfers, st_lasts;
  int st_rd_seq [N];
  int st_re_seq [N];
  int exp_seq [N];

  int errors = 0;
  int checks = 0;

  function automatic int m_map(input int k);
    int r;
`ifdef FFT_SEQ_BITREV_EN
    r = 0;
    for (int i = 0; i < 4; i++) r = r * 2 + ((k >> i) & 1);
`else
    r = k;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    st_acc16 = -1; st_start_cyc = -1; st_start_cnt = 0; st_done_cyc = -1;
    st_first_ov = -1; st_err_cnt = 0; st_err_cyc = -1; st_xfers = 0; st_lasts = 0;
    for (int i = 0; i < N; i++) begin st_rd_seq[i] = -1; st_re_seq[i] = -1; end
  endtask

  task automatic compare();
    bit ld;
    int a;
    ld = (m_ph == 0) && in_valid;
    a  = m_map(m_k);
    chk("in_ready",    in_ready,   m_ph == 0);
    chk("load_we",     load_we,    ld);
    chk("load_addr",   load_addr,  ld ? m_acc : 0);
    chk("load_re",     load_re,    ld ? in_re : 0);
    chk("load_im",     load_im,    ld ? in_im : 0);
    chk("core_start",  core_start, m_ph == 1);
    chk("busy",        busy,       !(m_ph == 0 && m_acc == 0));
    chk("out_valid",   out_valid,  m_ph == 3);
    chk("rd_addr",     rd_addr,    m_ph == 3 ? a : 0);
    chk("out_re",      out_re,     m_ph == 3 ? res_re[a] : 0);
    chk("out_im",      out_im,     m_ph == 3 ? res_im[a] : 0);
    chk("out_last",    out_last,   m_ph == 3 && m_k == N - 1);
    chk("err_timeout", err_timeout, m_err);
  endtask

  // One clock: drive inputs just after the rising edge, check at the falling edge,
  // then advance the model by what the next rising edge must do.
  task automatic step();
    bit done_now;
    bit err_n;
    @(posedge clk);
    #1;
    rst_n = !rst_req;
    if (rst_req) begin
      m_ph = 0; m_acc = 0; m_err = 0; done_cnt = 0;
    end
    done_now = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      done_now = (done_cnt == 0);
    end
    core_done = !rst_req && (done_now || (spurious && m_ph != 2 && $urandom_range(0, 2) == 0));
    if (rst_req) in_valid = 1'b0;
    else if (mode_in == 1) in_valid = 1'b1;
    else in_valid = ($urandom_range(0, 99) < p_valid);
    in_re = (mode_in == 1) ? DW'(m_acc) : DW'($urandom);
    in_im = (mode_in == 1) ? DW'(-m_acc) : DW'($urandom);
    out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 2) ? cyc[0] : 1'($urandom_range(0, 1));

    @(negedge clk);
    cyc++;
    compare();

    // core model reacts to the DUT's own strobes
    if (load_we) begin
      mem_re[load_addr] = load_re;
      mem_im[load_addr] = load_im;
    end
    if (core_start) begin
      for (int i = 0; i < N; i++) begin
        res_re[i] = mem_re[i] + 16'd100;
        res_im[i] = mem_im[i] ^ 16'h00ff;
      end
      if (core_delay > 0) done_cnt = core_delay;
      st_start_cnt++;
      st_start_cyc = cyc;
    end
    if (out_valid && st_first_ov < 0) st_first_ov = cyc;
    if (out_valid && out_ready) begin
      if (st_xfers < N) begin
        st_rd_seq[st_xfers] = rd_addr;
        st_re_seq[st_xfers] = out_re;
      end
      st_xfers++;
      if (out_last) st_lasts++;
    end
    if (err_timeout) begin st_err_cnt++; st_err_cyc = cyc; end

    err_n = 1'b0;
    case (m_ph)
      0: if (in_valid) begin
        if (m_acc == N - 1) begin m_acc = 0; m_ph = 1; st_acc16 = cyc; end
        else m_acc++;
      end
      1: begin m_ph = 2; m_wc = 0; end
      2: if (core_done) begin m_ph = 3; m_k = 0; st_done_cyc = cyc; end
         else if (m_wc == TIMEOUT - 1) begin m_ph = 0; err_n = 1'b1; end
         else m_wc++;
      3: if (out_ready) begin
        if (m_k == N - 1) begin m_ph = 0; m_frames++; end
        else m_k++;
      end
      default: m_ph = 0;
    endcase
    m_err = err_n;
  endtask

  task automatic run_frames(input int target, input int budget);
    int n = 0;
    while (m_frames < target && n < budget) begin step(); n++; end
    checks++;
    if (m_frames < target) begin
      errors++;
      $display("FAIL frame_budget: got %0d frames expected %0d (cycle %0d)", m_frames, target, cyc);
    end
  endtask

  task automatic run_until_err(input int budget);
    int n = 0;
    while (st_err_cnt == 0 && n < budget) begin step(); n++; end
    chk("timeout_seen", st_err_cnt, 1);
  endtask

  task automatic check_seq(input string name);
    for (int i = 0; i < N; i++) chk(name, st_rd_seq[i], exp_seq[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
`ifdef FFT_SEQ_BITREV_EN
    exp_seq = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
    for (int i = 0; i < N; i++) begin
      mem_re[i] = '0; mem_im[i] = '0; res_re[i] = '0; res_im[i] = '0;
    end
    cyc = 0; m_ph = 0; m_acc = 0; m_wc = 0; m_k = 0; m_frames = 0; m_err = 0; done_cnt = 0;
    mode_in = 0; p_valid = 0; or_mode = 0; core_delay = 9; spurious = 0;
    clear_stats();

    // reset state
    rst_req = 1;
    repeat (2) step();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    rst_req = 0;
    step();

    // nominal ramp frame
    clear_stats();
    mode_in = 1; or_mode = 0; core_delay = 9;
    run_frames(m_frames + 1, 200);
    chk("start_after_16th", st_start_cyc - st_acc16, 1);
    chk("start_pulses", st_start_cnt, 1);
    chk("done_after_start", st_done_cyc - st_start_cyc, 9);
    chk("first_ov_after_done", st_first_ov - st_done_cyc, 1);
    chk("nominal_xfers", st_xfers, 16);
    chk("nominal_lasts", st_lasts, 1);
    chk("first_out_re", st_re_seq[0], 100);
`ifdef FFT_SEQ_BITREV_EN
    chk("second_out_re", st_re_seq[1], 108);
`else
    chk("second_out_re", st_re_seq[1], 101);
`endif
    check_seq("rd_seq_nominal");

    // output back-pressure
    clear_stats();
    or_mode = 2;
    run_frames(m_frames + 1, 300);
    chk("bp_xfers", st_xfers, 16);
    chk("bp_lasts", st_lasts, 1);
    check_seq("rd_seq_bp");

    // timeout: core never answers
    clear_stats();
    or_mode = 0; core_delay = 0;
    run_until_err(300);
    chk("timeout_delay", st_err_cyc - (st_start_cyc + 1), 64);
    mode_in = 0; p_valid = 0;
    repeat (4) step();
    chk("timeout_pulses", st_err_cnt, 1);
    chk("timeout_no_ov", st_first_ov, -1);

    // done coinciding with expiry: done wins
    clear_stats();
    mode_in = 1; core_delay = 64;
    run_frames(m_frames + 1, 300);
    chk("coincide_no_err", st_err_cnt, 0);
    chk("coincide_xfers", st_xfers, 16);

    // done one cycle late: frame aborted, late done ignored in LOAD
    clear_stats();
    core_delay = 65;
    run_until_err(300);
    mode_in = 0; p_valid = 0;
    repeat (4) step();
    chk("late_no_ov", st_first_ov, -1);

    // randomized frames with spurious done and random back-pressure
    spurious = 1; mode_in = 0; p_valid = 70; or_mode = 1;
    for (int f = 0; f < 6; f++) begin
      core_delay = $urandom_range(1, 20);
      run_frames(m_frames + 1, 400);
    end

    // reset mid-load, then a clean ramp frame
    spurious = 0; core_delay = 9;
    for (int n = 0; n < 100 && !(m_ph == 0 && m_acc >= 5); n++) step();
    chk("midload_reached", m_acc >= 5, 1);
    rst_req = 1; step(); rst_req = 0;
    clear_stats();
    mode_in = 1; or_mode = 0;
    run_frames(m_frames + 1, 200);
    check_seq("rd_seq_after_reset");

    // reset mid-unload, then random traffic
    mode_in = 0; p_valid = 90; or_mode = 1;
    for (int n = 0; n < 300 && !(m_ph == 3 && m_k > 3); n++) step();
    chk("midunload_reached", m_ph == 3, 1);
    rst_req = 1; step(); rst_req = 0;
    run_frames(m_frames + 2, 600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_io_sequencer_radix2.md
# fft_io_sequencer_radix2

Host-side sequencer for the 16-point iterative radix-2 FFT core. It collects one frame of complex samples from an upstream valid/ready stream and writes them into the core's sample registers. It then issues a single-cycle start, waits for the core's done, and streams the results downstream with valid/ready and a last marker. It is the initiator/consumer at the other end of the core controller's start/done protocol.

## Interface
- `N`, 16: points per frame; power of two; `log2(N)` = 4 matches the core's four butterfly cycles.
- `DW`, 16: bits per real/imag component, two's complement.
- `TIMEOUT`, 64: maximum cycles in `WAIT` before the frame is aborted.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: upstream sample valid.
- `in_ready`  out  1: upstream sample accepted when `in_valid && in_ready`.
- `in_re`, `in_im`  in  DW: upstream sample.
- `load_we`  out  1: write strobe into the core sample registers.
- `load_addr`  out  log2(N): core sample register index.
- `load_re`, `load_im`  out  DW: sample written to the core.
- `core_start`  out  1: start pulse to the core controller.
- `core_done`  in  1: core controller done; high for exactly one cycle.
- `rd_addr`  out  log2(N): core result register index.
- `rd_re`, `rd_im`  in  DW: combinational read data from the core for `rd_addr`.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream ready.
- `out_re`, `out_im`  out  DW: result.
- `out_last`  out  1: marks the final result of a frame.
- `busy`  out  1: high in every state except `LOAD` with `idx`=0.
- `err_timeout`  out  1: one-cycle pulse when a frame is aborted.

## Operation
- States are `LOAD`, `START`, `WAIT` and `UNLOAD`. Reset enters `LOAD`. The index counter `idx` (log2(N) bits) and the watchdog counter `wdog` (`clog2(TIMEOUT+1)` bits) reset to 0.
- **`LOAD`**
  - `in_ready`=1.
  - Each handshake drives `load_we`=1 combinationally, with `load_addr`=`idx` and `load_re`/`load_im` = `in_re`/`in_im`. `idx` then increments.
  - The handshake at `idx`=N-1 wraps `idx` to 0 and moves to `START`.
- **`START`**
  - `core_start`=1 for exactly one cycle, then move to `WAIT` and clear `wdog`.
  - `start` is never held high, so the core cannot re-enter from its `DONE` state.
- **`WAIT`**
  - `in_ready`=0 and `out_valid`=0. `wdog` increments each cycle.
  - `core_done`=1 moves to `UNLOAD` with `idx`=0.
  - Otherwise, `wdog`=TIMEOUT-1 pulses `err_timeout`, moves to `LOAD` and drops the frame.
  - If `core_done` and expiry coincide, `core_done` wins.
- **`UNLOAD`**
  - `out_valid`=1, `rd_addr`=`map(idx)`, `out_re`/`out_im` = `rd_re`/`rd_im`, `out_last` = (`idx`==N-1).
  - Each handshake increments `idx`. The handshake with `out_last` moves to `LOAD` with `idx`=0.
  - While `out_ready`=0, `idx`, `rd_addr` and the data hold stable.
- `core_done` outside `WAIT` is ignored. `in_valid` outside `LOAD` is ignored and not back-pressured beyond `in_ready`=0.
- No arithmetic on sample data; widths pass through unchanged.

## Timing
- Reset values:
  - `in_ready`=1, because the state is `LOAD`.
  - All other outputs are 0: `load_we`, `load_addr`, `core_start`, `rd_addr`, `out_valid`, `out_last`, `busy`, `err_timeout`, and `out_re`/`out_im` (gated to 0 when `out_valid`=0).
- `core_start` is asserted in the cycle after the N-th input handshake.
- The core asserts done 9 cycles after its start edge, so `WAIT` nominally lasts 9 cycles.
- The first `out_valid` comes 1 cycle after the `core_done` cycle.
- Back-to-back throughput is one sample per cycle for load and for unload.
- Asynchronous reset mid-frame returns to `LOAD` immediately and discards partial input or output.
- The upstream source must restart the frame from sample 0.

## Configuration
- `FFT_SEQ_BITREV_EN` defined: `map(idx)` = bit-reverse of `idx` over log2(N) bits, so results leave in natural frequency order.
  - Example: `idx`=1 reads `rd_addr`=8.
- `FFT_SEQ_BITREV_EN` undefined: `map(idx)` = `idx`, so results leave in core register order.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → `in_ready`=1 and every other output 0. A subsequent frame of 16 samples loads `load_addr` 0..15 in order.
- **Nominal frame:** feed samples re=k, im=-k for k=0..15 with a core model whose done fires 9 cycles after start. Checks:
  - `core_start` is a single pulse one cycle after the 16th accept.
  - 16 outputs follow, with `out_last` only on the 16th.
- **Output back-pressure:** toggle `out_ready` every other cycle → `rd_addr` and data hold during stalls. Exactly 16 transfers occur with no duplicates or skips.
- **Timeout:** the core model never asserts done → `err_timeout` pulses once, 64 cycles after entering `WAIT`. The state returns to `LOAD` with `in_ready`=1 and no `out_valid`.
- **Bit-reverse on:** with `FFT_SEQ_BITREV_EN` defined, the `rd_addr` sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- **Bit-reverse off:** with `FFT_SEQ_BITREV_EN` undefined, the `rd_addr` sequence is 0..15.
- **Spurious done:** `core_done` pulses during `LOAD` → it is ignored and the load count is unaffected.
